// File: rtl/atm_keypad_entry_pkg.sv
// atm_keypad_entry_pkg: shared state enum, BCD digit type and decimal weights
package atm_keypad_entry_pkg;
   typedef enum logic {ENTRY, HOLD} state_e;
   typedef logic [3:0] bcd_t;
   localparam bcd_t DIGIT_MAX = 4'd9;
   localparam logic [15:0] POW10 [4] = '{16'd1, 16'd10, 16'd100, 16'd1000};
endpackage

// File: rtl/atm_btn_debounce.sv
// atm_btn_debounce: 2-flop sync, optional debouncer, one-cycle rising-edge pulse
// Debouncer present only when ATM_KEYPAD_DEBOUNCE_EN is defined.
module atm_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic pulse_o
);
   logic [1:0] sync_q;
   logic       lvl, lvl_q, pulse_q;
`ifdef ATM_KEYPAD_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          deb_q, deb_d;
   // any cycle agreeing with the accepted level restarts the count
   always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (sync_q[1] != deb_q) begin
         cnt_d = cnt_q + CW'(1);
         if (cnt_d == CW'(DEBOUNCE_CYCLES)) begin
            deb_d = sync_q[1];
            cnt_d = '0;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt_q <= '0;
         deb_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         deb_q <= deb_d;
      end
   assign lvl = deb_q;
`else
   logic deb_unused;
   assign deb_unused = DEBOUNCE_CYCLES[0];
   assign lvl = sync_q[1];
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync_q  <= '0;
         lvl_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         lvl_q   <= lvl;
         pulse_q <= lvl & ~lvl_q;
      end
   assign pulse_o = pulse_q;
endmodule

// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry: button/switch decimal entry, BCD to binary, valid/ready hand-off
// Button debouncing is enabled by defining ATM_KEYPAD_DEBOUNCE_EN.
module atm_keypad_entry
   import atm_keypad_entry_pkg::*;
#(
   parameter int DIGITS          = 4,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_commit,
   input  logic        btn_back,
   input  logic        btn_submit,
   input  logic        btn_clear,
   input  logic [3:0]  sw_digit,
   output logic [15:0] entry_value,
   output logic [2:0]  entry_count,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_value,
   output logic [2:0]  out_count,
   output logic        digit_err
);
   logic [3:0]  btn, pulse;
   logic        commit_p, back_p, submit_p, clear_p;
   bcd_t        sw1_q, sw2_q;
   state_e      state_q, state_d;
   bcd_t        dig_q [DIGITS];
   bcd_t        dig_d [DIGITS];
   logic [2:0]  cnt_q, cnt_d, ocnt_q, ocnt_d;
   logic [15:0] oval_q, oval_d, sum;
   assign btn = {btn_clear, btn_submit, btn_back, btn_commit};
   for (genvar g = 0; g < 4; g++) begin : g_btn
      atm_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
         .clk    (clk),
         .rst_n  (rst_n),
         .btn_i  (btn[g]),
         .pulse_o(pulse[g])
      );
   end
   assign {clear_p, submit_p, back_p, commit_p} = pulse;
   always_comb begin
      sum = '0;
      for (int i = 0; i < DIGITS; i++) sum = sum + 16'(dig_q[i]) * POW10[i];
   end
   // one branch per cycle gives the clear > submit > back > commit priority
   always_comb begin
      state_d   = state_q;
      dig_d     = dig_q;
      cnt_d     = cnt_q;
      oval_d    = oval_q;
      ocnt_d    = ocnt_q;
      digit_err = 1'b0;
      if (state_q == HOLD) begin
         if (clear_p || out_ready) begin
            state_d = ENTRY;
            cnt_d   = '0;
            dig_d   = '{default: '0};
         end
      end else if (clear_p) begin
         cnt_d = '0;
         dig_d = '{default: '0};
      end else if (submit_p) begin
         if (cnt_q != '0) begin
            state_d = HOLD;
            oval_d  = sum;
            ocnt_d  = cnt_q;
         end
      end else if (back_p) begin
         if (cnt_q != '0) begin
            for (int i = 0; i < DIGITS - 1; i++) dig_d[i] = dig_q[i+1];
            dig_d[DIGITS-1] = '0;
            cnt_d = cnt_q - 3'd1;
         end
      end else if (commit_p) begin
         if (sw2_q <= DIGIT_MAX && cnt_q < 3'(DIGITS)) begin
            for (int i = DIGITS - 1; i > 0; i--) dig_d[i] = dig_q[i-1];
            dig_d[0] = sw2_q;
            cnt_d = cnt_q + 3'd1;
         end else
            digit_err = 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= ENTRY;
         dig_q   <= '{default: '0};
         cnt_q   <= '0;
         oval_q  <= '0;
         ocnt_q  <= '0;
         sw1_q   <= '0;
         sw2_q   <= '0;
      end else begin
         state_q <= state_d;
         dig_q   <= dig_d;
         cnt_q   <= cnt_d;
         oval_q  <= oval_d;
         ocnt_q  <= ocnt_d;
         sw1_q   <= sw_digit;
         sw2_q   <= sw1_q;
      end
   assign entry_value = sum;
   assign entry_count = cnt_q;
   assign out_valid   = (state_q == HOLD);
   assign out_value   = oval_q;
   assign out_count   = ocnt_q;
endmodule

// File: tb/tb_atm_keypad_entry.sv
// tb_atm_keypad_entry: scoreboard bench for atm_keypad_entry
// Define ATM_KEYPAD_DEBOUNCE_EN to exercise the debouncer with DEBOUNCE_CYCLES=8.
module tb_atm_keypad_entry;
   localparam int DC = 8;
`ifdef ATM_KEYPAD_DEBOUNCE_EN
   localparam int PH = 20, ST = 24;
`else
   localparam int PH = 1, ST = 6;
`endif
   localparam logic [3:0] CM = 4'b0001, BK = 4'b0010, SB = 4'b0100, CL = 4'b1000;

   logic        clk, rst_n, btn_commit, btn_back, btn_submit, btn_clear, out_ready;
   logic [3:0]  sw_digit;
   logic [15:0] entry_value, out_value;
   logic [2:0]  entry_count, out_count;
   logic        out_valid, digit_err;

   atm_keypad_entry #(.DIGITS(4), .DEBOUNCE_CYCLES(DC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_commit (btn_commit),
      .btn_back   (btn_back),
      .btn_submit (btn_submit),
      .btn_clear  (btn_clear),
      .sw_digit   (sw_digit),
      .entry_value(entry_value),
      .entry_count(entry_count),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_value  (out_value),
      .out_count  (out_count),
      .digit_err  (digit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, errors = 0, err_seen = 0;
   int mv = 0, mc = 0, mov = 0, moc = 0;
   bit mh = 0;
   typedef struct {int v; int c; bit h; int ov; int oc; int e;} exp_t;
   exp_t sb[$];

   always @(negedge clk) if (digit_err === 1'b1) err_seen++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model(input logic [3:0] m, input int d, output int e);
      e = 0;
      if (mh) begin
         if (m[3]) begin mh = 0; mv = 0; mc = 0; end
      end else if (m[3]) begin
         mv = 0; mc = 0;
      end else if (m[2]) begin
         if (mc > 0) begin mh = 1; mov = mv; moc = mc; end
      end else if (m[1]) begin
         if (mc > 0) begin mv = mv / 10; mc--; end
      end else if (m[0]) begin
         if (d <= 9 && mc < 4) begin mv = mv * 10 + d; mc++; end
         else e = 1;
      end
   endtask

   task automatic push_exp(input int e);
      exp_t x;
      x = '{mv, mc, mh, mov, moc, e};
      sb.push_back(x);
   endtask

   task automatic pop_check(input string tag, input int e0);
      exp_t x;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 1, 0);
         return;
      end
      x = sb.pop_front();
      check({tag, "_value"}, entry_value, x.v);
      check({tag, "_count"}, entry_count, x.c);
      check({tag, "_valid"}, out_valid, x.h);
      if (x.h) begin
         check({tag, "_oval"}, out_value, x.ov);
         check({tag, "_ocnt"}, out_count, x.oc);
      end
      check({tag, "_err"}, err_seen - e0, x.e);
   endtask

   task automatic press(input string tag, input logic [3:0] m, input int d);
      int e, e0;
      model(m, d, e);
      push_exp(e);
      e0 = err_seen;
      sw_digit = 4'(d);
      {btn_clear, btn_submit, btn_back, btn_commit} = m;
      repeat (PH) @(negedge clk);
      {btn_clear, btn_submit, btn_back, btn_commit} = '0;
      repeat (ST) @(negedge clk);
      pop_check(tag, e0);
   endtask

   task automatic xfer(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      mh = 0; mv = 0; mc = 0;
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_count"}, entry_count, 0);
      check({tag, "_value"}, entry_value, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      rst_n = 1'b0; out_ready = 1'b0; sw_digit = '0;
      {btn_clear, btn_submit, btn_back, btn_commit} = '0;
      repeat (3) @(negedge clk);
      check("rst_value", entry_value, 0);
      check("rst_count", entry_count, 0);
      check("rst_valid", out_valid, 0);
      check("rst_oval", out_value, 0);
      check("rst_ocnt", out_count, 0);
      check("rst_err", digit_err, 0);
      rst_n = 1'b1;
      @(negedge clk);
`ifdef ATM_KEYPAD_DEBOUNCE_EN
      press("c1", CM, 1);
`else
      // clean press: pulse after 3 edges, registers update on the 4th
      sw_digit = 4'd1; btn_commit = 1'b1;
      e0 = err_seen;
      model(CM, 1, e0);
      push_exp(0);
      e0 = err_seen;
      repeat (3) @(negedge clk);
      check("lat_before", entry_count, 0);
      btn_commit = 1'b0;
      @(negedge clk);
      check("lat_after", entry_count, 1);
      repeat (ST) @(negedge clk);
      pop_check("c1", e0);
`endif
      press("c2", CM, 2);
      press("c3", CM, 3);
      press("c4", CM, 4);
      press("c5_full", CM, 5);
      press("sub1234", SB, 0);
      xfer("x1234");
      press("c7a", CM, 7);
      press("c7b", CM, 7);
      press("bk1", BK, 0);
      press("c3b", CM, 3);
      press("bk2", BK, 0);
      press("bk3", BK, 0);
      press("bk4_empty", BK, 0);
      press("c6", CM, 6);
      press("cA_bad", CM, 10);
      press("cF_bad", CM, 15);
      press("clr", CL, 0);
      for (int i = 0; i < 4; i++) press("c5555", CM, 5);
      press("sub5555", SB, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("hold_oval", out_value, 5555);
         check("hold_valid", out_valid, 1);
      end
      press("hold_commit", CM, 8);
      press("hold_back", BK, 0);
      xfer("x5555");
      press("c1p", CM, 1);
      press("c2p", CM, 2);
      press("prio", CM | BK | SB, 3);
      xfer("x12");
      press("sub_empty", SB, 0);
      press("c9", CM, 9);
      press("sub9", SB, 0);
      press("hold_clr", CL, 0);
`ifdef ATM_KEYPAD_DEBOUNCE_EN
      e0 = err_seen;
      push_exp(0);
      sw_digit = 4'd5; btn_commit = 1'b1;
      repeat (3) @(negedge clk);
      btn_commit = 1'b0;
      repeat (30) @(negedge clk);
      pop_check("glitch", e0);
      press("long", CM, 5);
`endif
      press("c4r", CM, 4);
      press("c2r", CM, 2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_value", entry_value, 0);
      check("arst_count", entry_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mv = 0; mc = 0; mh = 0; mov = 0; moc = 0;
      @(negedge clk);
      press("post_rst", CM, 8);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/atm_keypad_entry.md
# atm_keypad_entry

- Collects a multi-digit decimal number (account number, PIN, amount) from board pushbuttons and a 4-bit digit switch.
- Converts the number to binary and hands it to the ATM controller FSM over a valid/ready handshake.
- Exports the live partial value so the seven-segment display can echo it while the user types.
- Sits between the raw board inputs and the FSM; it is the user-to-machine direction, complementing the display path.

## Interface
Parameters:
- DIGITS, 4, maximum digits per entry (1..4; 9999 fits 16 bits)
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level (10 ms at 100 MHz)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- btn_commit  in  1  raw button (BTNC): append sw_digit
- btn_back  in  1  raw button (BTNL): delete last digit
- btn_submit  in  1  raw button (BTNR): submit entry
- btn_clear  in  1  raw button (BTND): discard entry
- sw_digit  in  4  digit value from switches; valid range 0..9
- entry_value  out  16  binary value of the digits entered so far (to display)
- entry_count  out  3  number of digits held, 0..DIGITS
- out_valid  out  1  submitted value available
- out_ready  in  1  FSM accepts the value
- out_value  out  16  submitted binary value
- out_count  out  3  digit count of the submitted value
- digit_err  out  1  one-cycle pulse on a rejected commit

## Operation
Input conditioning:
- Each button passes through a 2-flop synchronizer, then conditioning, then a rising-edge detector.
- The result is a one-cycle press pulse per press.
- sw_digit is also 2-flop synchronized and sampled on the commit pulse.

Storage:
- Digits are held as a BCD shift register d[DIGITS-1:0], with d0 the most recent.
- entry_value = Σ d[i]·10^i, computed combinationally from BCD.

States:
- ENTRY:
  - clear: count←0, all digits←0.
  - submit with count≥1: latch out_value←entry_value and out_count←count, then go to HOLD. With count=0 it is ignored.
  - back with count≥1: shift right and decrement count. With count=0 it is ignored.
  - commit with digit ≤9 and count<DIGITS: shift left, insert the digit, increment count.
  - commit with digit >9, or with count=DIGITS: no change, digit_err pulses.
- HOLD:
  - out_valid=1; out_value and out_count are held stable.
  - On out_valid&&out_ready, return to ENTRY with count←0 and digits←0.
  - btn_clear in HOLD drops out_valid and clears; the FSM must not rely on a value it has not yet accepted.
  - All other press pulses in HOLD are discarded. They are not queued.
- Simultaneous press pulses in one cycle: priority is clear > submit > back > commit. Lower-priority pulses are dropped.

Reset values:
- state=ENTRY; all outputs 0; all synchronizer, debounce and edge-detect state 0.
- Reset mid-entry or mid-HOLD discards everything immediately (asynchronous assertion).
- Release is sampled on clk.

## Timing
Button to press pulse:
- With debounce: a clean press produces its pulse 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) cycles after the first rising clk edge on which the button reads high.
- Without debounce: the same path is 3 cycles.

Register updates:
- Registers update on the clk edge following the pulse.
- entry_value and entry_count reflect the change one cycle after the pulse.
- digit_err is asserted in the same cycle the rejected commit pulse is consumed.

Handshake:
- Submit pulse → out_valid high the next cycle.
- The transfer completes on any edge where out_valid&&out_ready. out_valid falls the following cycle.
- out_ready may be held high permanently; the minimum HOLD time is then 1 cycle.
- out_ready is ignored when out_valid=0.
- A new entry can begin on the cycle after the transfer.

## Configuration
- ATM_KEYPAD_DEBOUNCE_EN defined: each synchronized button feeds a counter-based debouncer. The debounced level toggles only after DEBOUNCE_CYCLES consecutive cycles of a differing raw level; the counter resets on any bounce.
- Undefined: the debouncer is omitted and the synchronized level drives the edge detector directly. This is for simulation speed and for benches driving clean stimulus. DEBOUNCE_CYCLES is then unused.

## Structure
- Shared package: the state enum (ENTRY, HOLD), the BCD digit typedef, the limit constant 4'd9, and the 10^i weight constants.
- The sub-module is atm_btn_debounce, instantiated once per button: synchronizer + debouncer (under the macro) + edge pulse.
- The BCD-to-binary sum stays inline.

## Test plan
- Reset, then commit 1,2,3,4 → entry_value 1, 12, 123, 1234; count 4. Submit → out_valid=1, out_value=1234, out_count=4.
- Commit 7,7; back; commit 3 → entry_value 73, count 2. Back ×3 → count 0, value 0, no error.
- Commit with sw_digit=4'hA → digit_err 1 cycle, value unchanged. Fifth commit at count 4 → digit_err, value stays 1234.
- Submit 5555 with out_ready=0 for 20 cycles, then 1 → out_value stable at 5555 throughout. Commit presses during HOLD are ignored. Count 0 the cycle after the transfer.
- Same-cycle commit+back+submit pulses at value 12 → submit wins, out_value=12. Submit at count 0 → no out_valid.
- With ATM_KEYPAD_DEBOUNCE_EN and DEBOUNCE_CYCLES=8: a 3-cycle glitch → no pulse; a 20-cycle press → exactly one commit. Assert rst_n mid-entry at value 42 → entry_value 0 immediately.
